// File: rtl/pipelined_adder.sv
// pipelined_adder: valid/ready pipelined WIDTH-bit adder/subtractor, ripple chunks of CW bits
// with the carry registered between STAGES stages. Define ADDER_OVF_EN to enable the signed-overflow output.
module pipelined_adder #(
  parameter int WIDTH      = 16,
  parameter int STAGES     = 4,
  parameter int PATH_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW  = WIDTH / STAGES;
  localparam int L   = STAGES - 1;
  localparam int SKN = (STAGES > 1) ? STAGES - 1 : 1;

  // PATH_DELAY is kept for drop-in compatibility; registered outputs are driven with zero delay here.
  if ((STAGES < 1) || ((WIDTH % STAGES) != 0) || (PATH_DELAY < 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES >= 1, PATH_DELAY >= 0");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [WIDTH-1:0]  a_q [SKN];
  logic [WIDTH-1:0]  a_d [SKN];
  logic [WIDTH-1:0]  b_q [SKN];
  logic [WIDTH-1:0]  b_d [SKN];

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic              adv;
  logic              carry;
  logic [1:0]        fa;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Stage 0 reads the ports (B and carry already inverted for subtract); stage k reads stage k-1 registers.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_a[k] = a;
      assign src_b[k] = b ^ {WIDTH{sub}};
      assign src_c[k] = cin ^ sub;
      assign src_s[k] = '0;
      assign src_v[k] = in_valid;
    end else begin : g_body
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_c[k] = c_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_v[k] = v_q[k-1];
    end
  end

  always_comb begin
    carry = 1'b0;
    fa    = '0;
    v_d   = '0;
    c_d   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      s_d[k] = src_s[k];
      carry  = src_c[k];
      for (int unsigned i = 0; i < CW; i++) begin
        fa                 = full_add(src_a[k][k*CW+i], src_b[k][k*CW+i], carry);
        s_d[k][k*CW+i]     = fa[0];
        carry              = fa[1];
      end
      c_d[k] = carry;
      v_d[k] = src_v[k];
    end
    for (int unsigned k = 0; k < SKN; k++) begin
      a_d[k] = src_a[k];
      b_d[k] = src_b[k];
    end
  end

  assign adv = ~v_q[L] | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        s_q[k] <= '0;
      end
      for (int unsigned k = 0; k < SKN; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        s_q[k] <= s_d[k];
      end
      for (int unsigned k = 0; k < SKN; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

`ifdef ADDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = (src_a[L][WIDTH-1] == src_b[L][WIDTH-1]) & (s_d[L][WIDTH-1] != src_a[L][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = adv;
  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign cout      = c_q[L];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: scoreboard of model results, directed stall/reset steps,
// plus a WIDTH=8/STAGES=1 instance.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;
`ifdef ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  logic         in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
  logic [7:0]   a1, b1, sum1;

  pipelined_adder #(.WIDTH(W), .STAGES(S), .PATH_DELAY(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1), .PATH_DELAY(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          t;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   t     = 0;
  int   emits = 0;
  bit   chk_lat = 1'b1;

  // Returns {ovf, cout, sum} for a w-bit operation.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sm, input int unsigned w);
    logic [16:0] mask, yy, full;
    logic [15:0] s;
    logic        o;
    mask = (17'd1 << w) - 17'd1;
    yy   = sm ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
    full = ({1'b0, x} & mask) + yy + {16'd0, (sm ? ~ci : ci)};
    s    = full[15:0] & mask[15:0];
    o    = (x[w-1] == yy[w-1]) && (s[w-1] != x[w-1]);
    if (!OVF_ON) o = 1'b0;
    model = {o, full[w], s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    exp_t        e;
    logic [17:0] m;
    if (out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        if (e.lat) chk("latency", t - e.t, S);
        emits++;
      end
    end
    if (in_valid && in_ready === 1'b1) begin
      m     = model(a, b, cin, sub, 16);
      e.sum = m[15:0];
      e.cout = m[16];
      e.ovf = m[17];
      e.t   = t;
      e.lat = chk_lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    step();
    step();
  endtask

  task automatic rand_op();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  initial begin
    in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
    in_valid1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; out_ready1 = 1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    #11 rst_n = 1'b1;

    // Carry out of the full word: first edge after release accepts.
    a = 16'hFFFF; b = 16'h0001; cin = 0; sub = 0; in_valid = 1;
    step();
    in_valid = 0;
    step(); step(); step();
    chk("t1_valid", out_valid, 1);
    chk("t1_sum", sum, 16'h0000);
    chk("t1_cout", cout, 1);
    chk("t1_ovf", ovf, 0);
    drain(10);

    // Subtract with borrow, then signed overflow on subtract.
    a = 16'h0005; b = 16'h0007; cin = 0; sub = 1; in_valid = 1;
    step();
    a = 16'h8000; b = 16'h0001;
    step();
    in_valid = 0;
    step(); step();
    chk("t2a_sum", sum, 16'hFFFE);
    chk("t2a_cout", cout, 0);
    step();
    chk("t2b_sum", sum, 16'h7FFF);
    chk("t2b_cout", cout, 1);
    chk("t2b_ovf", ovf, OVF_ON);
    drain(10);

    // Back-to-back random stream.
    emits = 0;
    for (int i = 0; i < 8; i++) begin
      rand_op();
      in_valid = 1;
      chk("stream_in_ready", in_ready, 1);
      step();
    end
    in_valid = 0;
    drain(20);
    chk("stream_count", emits, 8);

    // Fill, stall three cycles with new operands offered, then release.
    chk_lat = 0;
    emits = 0;
    for (int i = 0; i < 4; i++) begin
      rand_op();
      in_valid = 1;
      step();
    end
    out_ready = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_sum", sum, sb[0].sum);
      chk("stall_cout", cout, sb[0].cout);
      step();
    end
    out_ready = 1;
    in_valid = 0;
    drain(20);
    chk("stall_count", emits, 4);
    chk_lat = 1;

    // Asynchronous reset mid-cycle with operations in flight.
    for (int i = 0; i < 4; i++) begin
      rand_op();
      in_valid = 1;
      step();
    end
    in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_cout", cout, 0);
    chk("async_rst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1;
    t++;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_in_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    a = 16'h1234; b = 16'h1111; cin = 0; sub = 0; in_valid = 1;
    step();
    in_valid = 0;
    step(); step(); step();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_sum", sum, 16'h2345);
    drain(10);

    // Single-stage 8-bit instance.
    a1 = 8'h7F; b1 = 8'h01; cin1 = 0; sub1 = 0; in_valid1 = 1;
    #1;
    chk("s1_in_ready", in_ready1, 1);
    chk("s1_idle_valid", out_valid1, 0);
    @(posedge clk);
    #1;
    a1 = 8'h00; b1 = 8'h01; sub1 = 1;
    chk("s1_valid", out_valid1, 1);
    chk("s1_sum", sum1, 8'h80);
    chk("s1_cout", cout1, 0);
    chk("s1_ovf", ovf1, OVF_ON);
    @(posedge clk);
    #1;
    in_valid1 = 0;
    chk("s1b_sum", sum1, model(16'h0000, 16'h0001, 1'b0, 1'b1, 8) & 18'hFF);
    chk("s1b_cout", cout1, 0);
    chk("s1b_ovf", ovf1, 0);
    @(posedge clk);
    #1;
    chk("s1_drained", out_valid1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
